// File: rtl/sysio_axil_bridge_pkg.sv
// Shared constants and types for the sysio AXI4-Lite bridge.
// Includes the response codes, the bus widths and the read FSM state encoding.
package sysio_axil_bridge_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_CAP  = 2'd1,
    R_RESP = 2'd2
  } rd_state_t;

  function automatic logic [1:0] resp_of(input logic mapped);
    return mapped ? RESP_OKAY : RESP_DECERR;
  endfunction

endpackage

// File: rtl/sysio_axil_bridge_slot_dec.sv
// Slot decoder: turns a 4-bit slot index into a one-hot peripheral select.
// Slots past NUM_SLOT or with a clear SLOT_EN bit yield all-zero and mapped=0.
module sysio_slot_dec
  import sysio_axil_bridge_pkg::*;
#(
  parameter int          NUM_SLOT = 16,
  parameter logic [15:0] SLOT_EN  = 16'hFFFF
) (
  input  logic [IDX_W-1:0]    i_idx,
  output logic [NUM_SLOT-1:0] o_onehot,
  output logic                o_mapped
);

  for (genvar k = 0; k < NUM_SLOT; k++) begin : g_slot
    assign o_onehot[k] = SLOT_EN[k] && (i_idx == IDX_W'(k));
  end

  assign o_mapped = |o_onehot;

endmodule

// File: rtl/sysio_axil_bridge.sv
// AXI4-Lite slave fanning one bus port out to NUM_SLOT sysio peripheral register ports.
// Independent AW/W capture with a real B channel; registered read data via a 3-state FSM.
//
// state  | meaning
// R_IDLE | arready high, waiting for an AR handshake (p_rd pulses on it)
// R_CAP  | peripheral presents data this cycle; rdata/rresp are captured
// R_RESP | rvalid high, rdata/rresp held until rready
module sysio_axil_bridge
  import sysio_axil_bridge_pkg::*;
#(
  parameter int          NUM_SLOT = 16,
  parameter int          SEL_LSB  = 8,
  parameter logic [15:0] SLOT_EN  = 16'hFFFF,
  parameter int          ADDR_W   = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [ADDR_W-1:0]          s_awaddr,
  input  logic                       s_awvalid,
  output logic                       s_awready,
  input  logic [DATA_W-1:0]          s_wdata,
  input  logic [STRB_W-1:0]          s_wstrb,
  input  logic                       s_wvalid,
  output logic                       s_wready,
  output logic [1:0]                 s_bresp,
  output logic                       s_bvalid,
  input  logic                       s_bready,
  input  logic [ADDR_W-1:0]          s_araddr,
  input  logic                       s_arvalid,
  output logic                       s_arready,
  output logic [DATA_W-1:0]          s_rdata,
  output logic [1:0]                 s_rresp,
  output logic                       s_rvalid,
  input  logic                       s_rready,
  output logic [SEL_LSB-1:0]         p_waddr,
  output logic [DATA_W-1:0]          p_wdata,
  output logic [STRB_W-1:0]          p_sel,
  output logic [NUM_SLOT-1:0]        p_we,
  output logic [SEL_LSB-1:0]         p_raddr,
  output logic [NUM_SLOT-1:0]        p_rd,
  input  logic [DATA_W*NUM_SLOT-1:0] p_rdata
);

  localparam int OFF_W = SEL_LSB - 2;

  // Held low through reset and for one clock after, so no ready is seen during reset.
  logic r_live;

  logic                r_aw_full;
  logic [IDX_W-1:0]    r_aw_idx;
  logic [OFF_W-1:0]    r_aw_off;
  logic                r_w_full;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_wstrb;
  logic                r_bvalid;
  logic [1:0]          r_bresp;

  logic                w_aw_hs;
  logic                w_w_hs;
  logic                w_issue;
  logic [NUM_SLOT-1:0] w_aw_onehot;
  logic                w_aw_mapped;

  rd_state_t           r_state;
  rd_state_t           w_state_nxt;
  logic                w_ar_hs;
  logic                w_rd_cap;
  logic [IDX_W-1:0]    w_ar_idx;
  logic [NUM_SLOT-1:0] w_ar_onehot;
  logic                w_ar_mapped;
  logic [NUM_SLOT-1:0] r_rd_onehot;
  logic                r_rd_mapped;
  logic [DATA_W-1:0]   r_rdata;
  logic [1:0]          r_rresp;
  logic [DATA_W-1:0]   w_rd_mux;

  logic                w_unused_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_live <= 1'b0;
    else        r_live <= 1'b1;
  end

  // ---------------- write path ----------------
  assign s_awready = r_live & ~r_aw_full;
  assign s_wready  = r_live & ~r_w_full;
  assign w_aw_hs   = s_awvalid & s_awready;
  assign w_w_hs    = s_wvalid & s_wready;
  assign w_issue   = r_aw_full & r_w_full & ~r_bvalid;

  sysio_slot_dec #(
    .NUM_SLOT (NUM_SLOT),
    .SLOT_EN  (SLOT_EN)
  ) u_aw_dec (
    .i_idx    (r_aw_idx),
    .o_onehot (w_aw_onehot),
    .o_mapped (w_aw_mapped)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aw_full <= 1'b0;
      r_aw_idx  <= '0;
      r_aw_off  <= '0;
      r_w_full  <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      if (w_aw_hs) begin
        r_aw_full <= 1'b1;
        r_aw_idx  <= s_awaddr[SEL_LSB+IDX_W-1:SEL_LSB];
        r_aw_off  <= s_awaddr[SEL_LSB-1:2];
      end else if (w_issue) begin
        r_aw_full <= 1'b0;
      end

      if (w_w_hs) begin
        r_w_full <= 1'b1;
        r_wdata  <= s_wdata;
        r_wstrb  <= s_wstrb;
      end else if (w_issue) begin
        r_w_full <= 1'b0;
      end

      if (w_issue) begin
        r_bvalid <= 1'b1;
        r_bresp  <= resp_of(w_aw_mapped);
      end else if (r_bvalid && s_bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  assign s_bvalid = r_bvalid;
  assign s_bresp  = r_bresp;
  assign p_we     = w_issue ? w_aw_onehot : '0;
  assign p_waddr  = {r_aw_off, 2'b00};
  assign p_wdata  = r_wdata;
  assign p_sel    = r_wstrb;

  // ---------------- read path ----------------
  assign w_ar_idx = s_araddr[SEL_LSB+IDX_W-1:SEL_LSB];
  assign w_ar_hs  = s_arvalid & s_arready;

  sysio_slot_dec #(
    .NUM_SLOT (NUM_SLOT),
    .SLOT_EN  (SLOT_EN)
  ) u_ar_dec (
    .i_idx    (w_ar_idx),
    .o_onehot (w_ar_onehot),
    .o_mapped (w_ar_mapped)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= R_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    s_arready   = 1'b0;
    s_rvalid    = 1'b0;
    w_rd_cap    = 1'b0;
    case (r_state)
      R_IDLE: begin
        s_arready = r_live;
        if (s_arvalid && r_live) w_state_nxt = R_CAP;
      end
      R_CAP: begin
        w_rd_cap    = 1'b1;
        w_state_nxt = R_RESP;
      end
      R_RESP: begin
        s_rvalid = 1'b1;
        if (s_rready) w_state_nxt = R_IDLE;
      end
      default: w_state_nxt = R_IDLE;
    endcase
  end

  assign p_rd    = w_ar_hs ? w_ar_onehot : '0;
  assign p_raddr = {s_araddr[SEL_LSB-1:2], 2'b00};

  // An unmapped read leaves the one-hot empty, so the mux itself returns zero.
  always_comb begin
    w_rd_mux = '0;
    for (int k = 0; k < NUM_SLOT; k++) begin
      w_rd_mux = w_rd_mux | (p_rdata[k*DATA_W +: DATA_W] & {DATA_W{r_rd_onehot[k]}});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_onehot <= '0;
      r_rd_mapped <= 1'b0;
      r_rdata     <= '0;
      r_rresp     <= RESP_OKAY;
    end else begin
      if (w_ar_hs) begin
        r_rd_onehot <= w_ar_onehot;
        r_rd_mapped <= w_ar_mapped;
      end
      if (w_rd_cap) begin
        r_rdata <= w_rd_mux;
        r_rresp <= resp_of(r_rd_mapped);
      end
    end
  end

  assign s_rdata = r_rdata;
  assign s_rresp = r_rresp;

  assign w_unused_addr = &{1'b0, s_awaddr[ADDR_W-1:SEL_LSB+IDX_W], s_awaddr[1:0],
                           s_araddr[ADDR_W-1:SEL_LSB+IDX_W], s_araddr[1:0]};

endmodule
